// File: rtl/sim_video_probe.sv
// sim_video_probe: sits between the core's raw VGA outputs and the simulation
// harness. Generates the pixel enable, tracks hpos/vpos from the sync edges,
// expands narrow colour to the harness width and measures active frame size.
module sim_video_probe #(
   parameter int IN_BITS   = 2,
   parameter int OUT_BITS  = 8,
   parameter int HPOS_W    = 10,
   parameter int VPOS_W    = 10,
   parameter int PIXEL_DIV = 4,
   parameter int FRAME_W   = 16
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                hs_in,
   input  logic                vs_in,
   input  logic                hblank_in,
   input  logic                vblank_in,
   input  logic [IN_BITS-1:0]  r_in,
   input  logic [IN_BITS-1:0]  g_in,
   input  logic [IN_BITS-1:0]  b_in,
   output logic                ce_pix,
   output logic                de,
   output logic                hs_out,
   output logic                vs_out,
   output logic [OUT_BITS-1:0] r_out,
   output logic [OUT_BITS-1:0] g_out,
   output logic [OUT_BITS-1:0] b_out,
   output logic [HPOS_W-1:0]   hpos,
   output logic [VPOS_W-1:0]   vpos,
   output logic [FRAME_W-1:0]  frame_count,
   output logic [HPOS_W-1:0]   active_w,
   output logic [VPOS_W-1:0]   active_h,
   output logic                geom_valid
);

   localparam int DIV_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);

   // Replicate the input channel MSB-first and truncate to OUT_BITS.
   function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
      logic [OUT_BITS-1:0] res;
      res = '0;
      for (int i = 0; i < OUT_BITS; i++) begin
         res[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
      end
      return res;
   endfunction

   // Horizontal-width increment that sticks at all-ones instead of wrapping.
   function automatic logic [HPOS_W-1:0] sat_inc_h(input logic [HPOS_W-1:0] x);
      return (&x) ? x : x + HPOS_W'(1);
   endfunction

   // Vertical-width increment that sticks at all-ones instead of wrapping.
   function automatic logic [VPOS_W-1:0] sat_inc_v(input logic [VPOS_W-1:0] x);
      return (&x) ? x : x + VPOS_W'(1);
   endfunction

   logic [DIV_W-1:0]  div_cnt;
   logic              hs_prev;
   logic              vs_prev;
   logic              vld_p0;
   logic              de_p0;
   logic              hs_rise_p0;
   logic              vs_rise_p0;
   logic [HPOS_W-1:0] line_cnt;
   logic [HPOS_W-1:0] max_w;
   logic [VPOS_W-1:0] lines;
   logic              armed;
   logic [HPOS_W-1:0] fold_w_p0;
   logic [VPOS_W-1:0] fold_lines_p0;

   // Pixel enable is held low during reset so the first pulse lands in the
   // first cycle after release, when the divider count is still 0.
   assign ce_pix = ~reset & (div_cnt == '0);
   assign vld_p0 = ce_pix;

   // Free-running divider 0..PIXEL_DIV-1.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // ---- p0: sample decode (combinational, qualified by vld_p0) ----
   // Edge detection, data-enable and the "fold pending line" values.
   always_comb begin
      de_p0         = ~(hblank_in | vblank_in);
      hs_rise_p0    = hs_in & ~hs_prev;
      vs_rise_p0    = vs_in & ~vs_prev;
      fold_w_p0     = (line_cnt > max_w) ? line_cnt : max_w;
      fold_lines_p0 = (line_cnt != '0) ? sat_inc_v(lines) : lines;
   end

   // ---- p1: registered outputs, updated one cycle after each sample ----
   // Sync/de pass-through, edge history and colour expansion.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hs_prev <= 1'b0;
         vs_prev <= 1'b0;
         de      <= 1'b0;
         hs_out  <= 1'b0;
         vs_out  <= 1'b0;
         r_out   <= '0;
         g_out   <= '0;
         b_out   <= '0;
      end else if (vld_p0) begin
         hs_prev <= hs_in;
         vs_prev <= vs_in;
         de      <= de_p0;
         hs_out  <= hs_in;
         vs_out  <= vs_in;
         r_out   <= de_p0 ? expand(r_in) : '0;
         g_out   <= de_p0 ? expand(g_in) : '0;
         b_out   <= de_p0 ? expand(b_in) : '0;
      end
   end

   // Beam position: hs edge restarts the line, vs edge restarts the frame.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hpos <= '0;
         vpos <= '0;
      end else if (vld_p0) begin
         if (hs_rise_p0) begin
            hpos <= '0;
         end else begin
            hpos <= sat_inc_h(hpos);
         end
         if (vs_rise_p0) begin
            vpos <= '0;
         end else if (hs_rise_p0) begin
            vpos <= sat_inc_v(vpos);
         end
      end
   end

   // Geometry accumulation; a vs edge folds the pending line then commits
   // the frame, but only once the first vs edge after reset has armed it.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         line_cnt    <= '0;
         max_w       <= '0;
         lines       <= '0;
         armed       <= 1'b0;
         active_w    <= '0;
         active_h    <= '0;
         geom_valid  <= 1'b0;
         frame_count <= '0;
      end else if (vld_p0) begin
         if (vs_rise_p0) begin
            if (armed) begin
               active_w    <= fold_w_p0;
               active_h    <= fold_lines_p0;
               geom_valid  <= 1'b1;
               frame_count <= frame_count + FRAME_W'(1);
            end
            max_w    <= '0;
            lines    <= '0;
            line_cnt <= '0;
            armed    <= 1'b1;
         end else if (hs_rise_p0) begin
            max_w    <= fold_w_p0;
            lines    <= fold_lines_p0;
            line_cnt <= '0;
         end else if (de_p0) begin
            line_cnt <= sat_inc_h(line_cnt);
         end
      end
   end

endmodule

// File: tb/tb_sim_video_probe.sv
// Directed bench for sim_video_probe with default parameters (PIXEL_DIV=4).
module tb_sim_video_probe;

   logic       clk_sys;
   logic       reset;
   logic       hs_in, vs_in, hblank_in, vblank_in;
   logic [1:0] r_in, g_in, b_in;
   logic       ce_pix, de, hs_out, vs_out;
   logic [7:0] r_out, g_out, b_out;
   logic [9:0] hpos, vpos, active_w, active_h;
   logic [15:0] frame_count;
   logic       geom_valid;

   int n_checks;
   int n_fail;

   sim_video_probe dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .hblank_in   (hblank_in),
      .vblank_in   (vblank_in),
      .r_in        (r_in),
      .g_in        (g_in),
      .b_in        (b_in),
      .ce_pix      (ce_pix),
      .de          (de),
      .hs_out      (hs_out),
      .vs_out      (vs_out),
      .r_out       (r_out),
      .g_out       (g_out),
      .b_out       (b_out),
      .hpos        (hpos),
      .vpos        (vpos),
      .frame_count (frame_count),
      .active_w    (active_w),
      .active_h    (active_h),
      .geom_valid  (geom_valid)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Present one pixel on the next ce_pix cycle; returns just after the sampling edge.
   task automatic pix(input logic hs, input logic vs, input logic hb, input logic vb,
                      input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
      int k;
      k = 0;
      @(negedge clk_sys);
      while (!ce_pix && k < 32) begin
         @(negedge clk_sys);
         k++;
      end
      if (!ce_pix) begin
         check("ce_pix_timeout", 32'(ce_pix), 32'd1);
      end else begin
         hs_in = hs; vs_in = vs; hblank_in = hb; vblank_in = vb;
         r_in = r; g_in = g; b_in = b;
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Line 0 carries vs, lines 0-1 are vblank, then nact active lines.
   task automatic frame(input int len, input int act, input int hs_at, input int nact);
      for (int ln = 0; ln < 2 + nact; ln++) begin
         for (int p = 0; p < len; p++) begin
            pix((p >= hs_at) && (p < hs_at + 5), ln == 0, p >= act, ln < 2,
                2'b01, 2'b10, 2'b11);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      hs_in = 1'b0; vs_in = 1'b0; hblank_in = 1'b1; vblank_in = 1'b1;
      r_in = 2'b00; g_in = 2'b00; b_in = 2'b00;

      // Reset state
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_ce_pix", 32'(ce_pix), 32'd0);
      check("rst_de", 32'(de), 32'd0);
      check("rst_hpos", 32'(hpos), 32'd0);
      check("rst_vpos", 32'(vpos), 32'd0);
      check("rst_geom_valid", 32'(geom_valid), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);

      // Divider pattern after release: ce_pix in cycles 0, 4, 8
      reset = 1'b0;
      #1;
      for (int k = 0; k < 9; k++) begin
         check($sformatf("ce_pix_c%0d", k), 32'(ce_pix), (k % 4 == 0) ? 32'd1 : 32'd0);
         check($sformatf("de_c%0d", k), 32'(de), 32'd0);
         check($sformatf("geom_c%0d", k), 32'(geom_valid), 32'd0);
         @(negedge clk_sys);
         #1;
      end

      // Colour expansion and blanking
      pix(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b11);
      check("de_active", 32'(de), 32'd1);
      check("r_out_AA", 32'(r_out), 32'hAA);
      check("g_out_55", 32'(g_out), 32'h55);
      check("b_out_FF", 32'(b_out), 32'hFF);
      pix(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b11);
      check("de_hblank", 32'(de), 32'd0);
      check("r_out_blank", 32'(r_out), 32'd0);
      check("g_out_blank", 32'(g_out), 32'd0);
      check("b_out_blank", 32'(b_out), 32'd0);

      // Synthetic frames: 200-pixel lines, 160 active, hs at 180, 10 active lines
      frame(200, 160, 180, 10);
      check("geom_after_arm", 32'(geom_valid), 32'd0);
      frame(200, 160, 180, 10);
      check("geom_valid_f", 32'(geom_valid), 32'd1);
      check("active_w_160", 32'(active_w), 32'd160);
      check("active_h_10", 32'(active_h), 32'd10);
      check("frame_count_1", 32'(frame_count), 32'd1);
      check("hpos_line_end", 32'(hpos), 32'd19);
      check("vpos_frame_end", 32'(vpos), 32'd12);

      // Pending 170-pixel line, then hs and vs rise in the same sample
      for (int p = 0; p < 170; p++) pix(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
      check("hpos_pending", 32'(hpos), 32'd189);
      pix(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);
      check("hpos_both", 32'(hpos), 32'd0);
      check("vpos_both", 32'(vpos), 32'd0);
      check("active_w_pending", 32'(active_w), 32'd170);
      check("active_h_pending", 32'(active_h), 32'd11);
      check("frame_count_2", 32'(frame_count), 32'd2);

      // hpos saturation without any hs edge
      for (int p = 0; p < 1000; p++) pix(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);
      check("hpos_1000", 32'(hpos), 32'd1000);
      for (int p = 0; p < 23; p++) pix(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);
      check("hpos_1023", 32'(hpos), 32'd1023);
      for (int p = 0; p < 77; p++) pix(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);
      check("hpos_sat", 32'(hpos), 32'd1023);
      check("vpos_hold", 32'(vpos), 32'd0);

      // Mid-frame reset after a valid measurement
      @(negedge clk_sys);
      reset = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      check("mrst_ce_pix", 32'(ce_pix), 32'd0);
      check("mrst_hpos", 32'(hpos), 32'd0);
      check("mrst_active_w", 32'(active_w), 32'd0);
      check("mrst_active_h", 32'(active_h), 32'd0);
      check("mrst_frame_count", 32'(frame_count), 32'd0);
      check("mrst_geom_valid", 32'(geom_valid), 32'd0);
      @(negedge clk_sys);
      reset = 1'b0;

      frame(40, 30, 34, 3);
      check("post_rst_geom_first_vs", 32'(geom_valid), 32'd0);
      check("post_rst_active_w_first_vs", 32'(active_w), 32'd0);
      frame(40, 30, 34, 3);
      check("post_rst_geom_second_vs", 32'(geom_valid), 32'd1);
      check("post_rst_active_w", 32'(active_w), 32'd30);
      check("post_rst_active_h", 32'(active_h), 32'd3);
      check("post_rst_frame_count", 32'(frame_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
